// File: rtl/mux4to1_rr_arbiter.sv
// mux4to1_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4-to-1 word multiplexer.
//   It grants one requester at a time for a burst of up to MAX_BURST words,
//   drives the mux select lines, and registers the selected word onto f.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req[3:0]      request per requester, held until its transfers are done
//   w0..w3        requester data words (WIDTH bits)
//   gnt[3:0]      registered one-hot grant, zero when idle
//   s1, s0        registered mux select, {s1,s0} == granted index
//   f             registered selected word
//   f_valid       one-cycle strobe per transferred word
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any req
// BUSY  | gnt[sel] active, transferring w[sel] while req[sel] holds
module mux4to1_rr_arbiter #(
    parameter int WIDTH     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    output logic [3:0]       gnt,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] f,
    output logic             f_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t           state;
    logic [1:0]       sel;
    logic [1:0]       last;
    logic [3:0]       cnt;

    logic [WIDTH-1:0] w_cur;
    logic             xfer;
    logic             release_now;
    logic [2:0]       idle_pick;
    logic [2:0]       rel_pick;

    // Returns {found, index}: first set bit of r searching p, p+1, p+2, p+3 (mod 4).
    // Walking backwards lets the closest candidate overwrite the farther ones.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        w_cur = w0;
        case (sel)
            2'd0: w_cur = w0;
            2'd1: w_cur = w1;
            2'd2: w_cur = w2;
            2'd3: w_cur = w3;
            default: w_cur = w0;
        endcase
    end

    assign xfer        = (state == BUSY) && gnt[sel] && req[sel];
    assign release_now = (state == BUSY) && (!req[sel] || (xfer && (cnt == CNT_LAST)));
    assign idle_pick   = rr_pick(req, last + 2'd1);
    // Searching from sel+1 puts the current owner last, so after an exhausted
    // burst it is re-granted only when nobody else is asking.
    assign rel_pick    = rr_pick(req, sel + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 2'd0;
            last    <= 2'd3;
            cnt     <= 4'd0;
            gnt     <= 4'b0000;
            f       <= '0;
            f_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    f_valid <= 1'b0;
                    if (idle_pick[2]) begin
                        sel   <= idle_pick[1:0];
                        last  <= idle_pick[1:0];
                        gnt   <= 4'b0001 << idle_pick[1:0];
                        cnt   <= 4'd0;
                        state <= BUSY;
                    end else begin
                        gnt <= 4'b0000;
                    end
                end
                BUSY: begin
                    f_valid <= xfer;
                    if (xfer) begin
                        f   <= w_cur;
                        cnt <= cnt + 4'd1;
                    end
                    if (release_now) begin
                        if (rel_pick[2]) begin
                            sel  <= rel_pick[1:0];
                            last <= rel_pick[1:0];
                            gnt  <= 4'b0001 << rel_pick[1:0];
                            cnt  <= 4'd0;
                        end else begin
                            gnt   <= 4'b0000;
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule
